// File: rtl/instr_cycle_sequencer.sv
// Instruction-cycle sequencer: steps FETCH/DECODE/READ/EXEC/MEM/WB per opcode class
// and presents the current cycle state to the CPU control matrix.
module instr_cycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 8,
  parameter int unsigned COUNT_W     = 8
) (
  input  logic               clock,
  input  logic               state_machine_reset,
  input  logic               run,
  input  logic [3:0]         opcode,
  input  logic               mem_ready,
  output logic [2:0]         state,
  output logic [3:0]         opcode_store,
  output logic               fetch_strobe,
  output logic               halted,
  output logic               mem_timeout,
  output logic [COUNT_W-1:0] instr_count
);

  localparam int unsigned WAIT_W = 8;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_LOAD   = 4'h8;
  localparam logic [3:0] OP_STORE  = 4'h9;
  localparam logic [3:0] OP_BRANCH = 4'hA;
  localparam logic [3:0] OP_HALT   = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_READ   = 3'd3,
    S_EXEC   = 3'd4,
    S_MEM    = 3'd5,
    S_WB     = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  state_t              cur;
  state_t              nxt;
  logic [WAIT_W-1:0]   wait_q;
  logic [WAIT_W-1:0]   wait_d;
  logic [3:0]          opc_d;
  logic                fs_d;
  logic                to_d;
  logic                retire;
  logic                expired;
  logic [COUNT_W-1:0]  cnt_d;

  // Limit reached with the RAM still not ready: this cycle must give up.
  assign expired = (wait_q == WAIT_W'(MEM_TIMEOUT)) && !mem_ready;

  assign state = cur;

  always_comb begin
    nxt    = cur;
    opc_d  = opcode_store;
    fs_d   = 1'b0;
    to_d   = mem_timeout;
    retire = 1'b0;
    wait_d = wait_q;
    cnt_d  = instr_count;

    case (cur)
      S_IDLE: begin
        if (run) nxt = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ready) begin
          opc_d = opcode;
          fs_d  = 1'b1;
          nxt   = S_DECODE;
        end else if (expired) begin
          nxt  = S_HALT;
          to_d = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode_store)
          OP_NOP, 4'hB, 4'hC, 4'hD, 4'hE: begin
            nxt    = S_FETCH;
            retire = 1'b1;
          end
          OP_HALT: begin
            nxt    = S_HALT;
            retire = 1'b1;
          end
          default: nxt = S_READ;
        endcase
      end
      S_READ: nxt = S_EXEC;
      S_EXEC: begin
        case (opcode_store)
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: nxt = S_WB;
          OP_LOAD, OP_STORE: nxt = S_MEM;
          OP_BRANCH: begin
            nxt    = S_FETCH;
            retire = 1'b1;
          end
          default: nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (opcode_store == OP_LOAD) begin
            nxt = S_WB;
          end else begin
            nxt    = S_FETCH;
            retire = 1'b1;
          end
        end else if (expired) begin
          nxt  = S_HALT;
          to_d = 1'b1;
        end
      end
      S_WB: begin
        nxt    = S_FETCH;
        retire = 1'b1;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase

    // Any state change restarts the wait count; staying put while waiting advances it.
    if (nxt != cur) begin
      wait_d = '0;
    end else if (((cur == S_FETCH) || (cur == S_MEM)) && !mem_ready) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    cnt_d = instr_count + COUNT_W'(retire);
  end

  always_ff @(posedge clock) begin
    if (state_machine_reset) begin
      cur          <= S_IDLE;
      wait_q       <= '0;
      opcode_store <= '0;
      fetch_strobe <= 1'b0;
      halted       <= 1'b0;
      mem_timeout  <= 1'b0;
      instr_count  <= '0;
    end else begin
      cur          <= nxt;
      wait_q       <= wait_d;
      opcode_store <= opc_d;
      fetch_strobe <= fs_d;
      halted       <= (nxt == S_HALT);
      mem_timeout  <= to_d;
      instr_count  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_instr_cycle_sequencer.sv
// Bench for instr_cycle_sequencer: vector table through a scoreboard on the default
// instance, plus hand sequences on a narrow-counter, short-timeout instance.
module tb_instr_cycle_sequencer;

  logic       clock;
  logic       state_machine_reset;
  logic       run;
  logic [3:0] opcode;
  logic       mem_ready;

  logic [2:0] state;
  logic [3:0] opcode_store;
  logic       fetch_strobe;
  logic       halted;
  logic       mem_timeout;
  logic [7:0] instr_count;

  logic [2:0] state2;
  logic [3:0] opcode_store2;
  logic       fetch_strobe2;
  logic       halted2;
  logic       mem_timeout2;
  logic [1:0] instr_count2;

  instr_cycle_sequencer #(.MEM_TIMEOUT(8), .COUNT_W(8)) dut (
    .clock(clock), .state_machine_reset(state_machine_reset), .run(run),
    .opcode(opcode), .mem_ready(mem_ready), .state(state),
    .opcode_store(opcode_store), .fetch_strobe(fetch_strobe), .halted(halted),
    .mem_timeout(mem_timeout), .instr_count(instr_count)
  );

  instr_cycle_sequencer #(.MEM_TIMEOUT(1), .COUNT_W(2)) dut2 (
    .clock(clock), .state_machine_reset(state_machine_reset), .run(run),
    .opcode(opcode), .mem_ready(mem_ready), .state(state2),
    .opcode_store(opcode_store2), .fetch_strobe(fetch_strobe2), .halted(halted2),
    .mem_timeout(mem_timeout2), .instr_count(instr_count2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] os;
    logic       fs;
    logic       hl;
    logic       to;
    logic [7:0] cnt;
  } out_t;

  typedef struct {
    logic       rst;
    logic       run;
    logic [3:0] opc;
    logic       rdy;
    out_t       exp;
    string      name;
  } vec_t;

  vec_t vecs[$];
  out_t exp_q[$];
  int   vec_cnt = 0;
  int   miss_cnt = 0;

  task automatic add_vec(input logic rst, input logic r, input logic [3:0] opc, input logic rdy,
                         input logic [2:0] st, input logic [3:0] os, input logic fs,
                         input logic hl, input logic to, input logic [7:0] cnt, input string nm);
    vec_t t;
    t.rst = rst; t.run = r; t.opc = opc; t.rdy = rdy;
    t.exp = '{st: st, os: os, fs: fs, hl: hl, to: to, cnt: cnt};
    t.name = nm;
    vecs.push_back(t);
  endtask

  task automatic add_reset(input string nm);
    add_vec(1, 0, 4'h0, 0, 3'd0, 4'h0, 0, 0, 0, 8'd0, nm);
  endtask

  task automatic drive(input logic rst, input logic r, input logic [3:0] opc, input logic rdy);
    @(negedge clock);
    state_machine_reset = rst; run = r; opcode = opc; mem_ready = rdy;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  initial begin
    out_t got;
    out_t e;
    state_machine_reset = 1'b1; run = 1'b0; opcode = 4'h0; mem_ready = 1'b0;

    add_reset("rst0");
    add_reset("rst1");
    // ALU opcode, ready immediately
    add_vec(0, 1, 4'h1, 1, 3'd1, 4'h0, 0, 0, 0, 8'd0, "alu_fetch");
    add_vec(0, 1, 4'h1, 1, 3'd2, 4'h1, 1, 0, 0, 8'd0, "alu_decode");
    add_vec(0, 1, 4'h1, 1, 3'd3, 4'h1, 0, 0, 0, 8'd0, "alu_read");
    add_vec(0, 1, 4'h1, 1, 3'd4, 4'h1, 0, 0, 0, 8'd0, "alu_exec");
    add_vec(0, 1, 4'h1, 1, 3'd6, 4'h1, 0, 0, 0, 8'd0, "alu_wb");
    add_vec(0, 1, 4'h1, 1, 3'd1, 4'h1, 0, 0, 0, 8'd1, "alu_retire");
    // LOAD with three wait cycles in MEM
    add_vec(0, 0, 4'h8, 1, 3'd2, 4'h8, 1, 0, 0, 8'd1, "ld_decode");
    add_vec(0, 0, 4'h8, 1, 3'd3, 4'h8, 0, 0, 0, 8'd1, "ld_read");
    add_vec(0, 0, 4'h8, 1, 3'd4, 4'h8, 0, 0, 0, 8'd1, "ld_exec");
    add_vec(0, 0, 4'h8, 1, 3'd5, 4'h8, 0, 0, 0, 8'd1, "ld_mem");
    for (int i = 0; i < 3; i++)
      add_vec(0, 0, 4'h8, 0, 3'd5, 4'h8, 0, 0, 0, 8'd1, "ld_wait");
    add_vec(0, 0, 4'h8, 1, 3'd6, 4'h8, 0, 0, 0, 8'd1, "ld_wb");
    add_vec(0, 0, 4'h8, 1, 3'd1, 4'h8, 0, 0, 0, 8'd2, "ld_retire");
    // STORE retires out of MEM
    add_vec(0, 0, 4'h9, 1, 3'd2, 4'h9, 1, 0, 0, 8'd2, "st_decode");
    add_vec(0, 0, 4'h9, 1, 3'd3, 4'h9, 0, 0, 0, 8'd2, "st_read");
    add_vec(0, 0, 4'h9, 1, 3'd4, 4'h9, 0, 0, 0, 8'd2, "st_exec");
    add_vec(0, 0, 4'h9, 1, 3'd5, 4'h9, 0, 0, 0, 8'd2, "st_mem");
    add_vec(0, 0, 4'h9, 1, 3'd1, 4'h9, 0, 0, 0, 8'd3, "st_retire");
    // NOP, reserved, BRANCH
    add_vec(0, 0, 4'h0, 1, 3'd2, 4'h0, 1, 0, 0, 8'd3, "nop_decode");
    add_vec(0, 0, 4'h0, 1, 3'd1, 4'h0, 0, 0, 0, 8'd4, "nop_retire");
    add_vec(0, 0, 4'hC, 1, 3'd2, 4'hC, 1, 0, 0, 8'd4, "rsv_decode");
    add_vec(0, 0, 4'hC, 1, 3'd1, 4'hC, 0, 0, 0, 8'd5, "rsv_retire");
    add_vec(0, 0, 4'hA, 1, 3'd2, 4'hA, 1, 0, 0, 8'd5, "br_decode");
    add_vec(0, 0, 4'hA, 1, 3'd3, 4'hA, 0, 0, 0, 8'd5, "br_read");
    add_vec(0, 0, 4'hA, 1, 3'd4, 4'hA, 0, 0, 0, 8'd5, "br_exec");
    add_vec(0, 0, 4'hA, 1, 3'd1, 4'hA, 0, 0, 0, 8'd6, "br_retire");
    // FETCH waits eight cycles; ready in the limit cycle wins
    for (int i = 0; i < 8; i++)
      add_vec(0, 0, 4'hF, 0, 3'd1, 4'hA, 0, 0, 0, 8'd6, "fetch_wait");
    add_vec(0, 0, 4'hF, 1, 3'd2, 4'hF, 1, 0, 0, 8'd6, "halt_decode");
    add_vec(0, 0, 4'hF, 1, 3'd7, 4'hF, 0, 1, 0, 8'd7, "halt_enter");
    add_vec(0, 1, 4'h1, 1, 3'd7, 4'hF, 0, 1, 0, 8'd7, "halt_hold");
    add_reset("rst_from_halt");
    // FETCH timeout
    add_vec(0, 1, 4'h0, 0, 3'd1, 4'h0, 0, 0, 0, 8'd0, "to_fetch");
    for (int i = 0; i < 8; i++)
      add_vec(0, 1, 4'h0, 0, 3'd1, 4'h0, 0, 0, 0, 8'd0, "to_fetch_wait");
    add_vec(0, 1, 4'h0, 0, 3'd7, 4'h0, 0, 1, 1, 8'd0, "to_fetch_halt");
    add_vec(0, 1, 4'h1, 1, 3'd7, 4'h0, 0, 1, 1, 8'd0, "to_sticky0");
    add_vec(0, 1, 4'h1, 1, 3'd7, 4'h0, 0, 1, 1, 8'd0, "to_sticky1");
    add_reset("rst_from_timeout");
    // MEM timeout on a LOAD
    add_vec(0, 1, 4'h8, 1, 3'd1, 4'h0, 0, 0, 0, 8'd0, "mto_fetch");
    add_vec(0, 0, 4'h8, 1, 3'd2, 4'h8, 1, 0, 0, 8'd0, "mto_decode");
    add_vec(0, 0, 4'h8, 1, 3'd3, 4'h8, 0, 0, 0, 8'd0, "mto_read");
    add_vec(0, 0, 4'h8, 1, 3'd4, 4'h8, 0, 0, 0, 8'd0, "mto_exec");
    add_vec(0, 0, 4'h8, 1, 3'd5, 4'h8, 0, 0, 0, 8'd0, "mto_mem");
    for (int i = 0; i < 8; i++)
      add_vec(0, 0, 4'h8, 0, 3'd5, 4'h8, 0, 0, 0, 8'd0, "mto_wait");
    add_vec(0, 0, 4'h8, 0, 3'd7, 4'h8, 0, 1, 1, 8'd0, "mto_halt");
    add_reset("rst_from_mto");
    // Five ALU ops, then reset while in EXEC
    add_vec(0, 1, 4'h3, 1, 3'd1, 4'h0, 0, 0, 0, 8'd0, "alu5_start");
    for (int i = 0; i < 5; i++) begin
      add_vec(0, 0, 4'h3, 1, 3'd2, 4'h3, 1, 0, 0, 8'(i), "alu5_decode");
      add_vec(0, 0, 4'h3, 1, 3'd3, 4'h3, 0, 0, 0, 8'(i), "alu5_read");
      add_vec(0, 0, 4'h3, 1, 3'd4, 4'h3, 0, 0, 0, 8'(i), "alu5_exec");
      add_vec(0, 0, 4'h3, 1, 3'd6, 4'h3, 0, 0, 0, 8'(i), "alu5_wb");
      add_vec(0, 0, 4'h3, 1, 3'd1, 4'h3, 0, 0, 0, 8'(i + 1), "alu5_retire");
    end
    add_vec(0, 0, 4'h2, 1, 3'd2, 4'h2, 1, 0, 0, 8'd5, "mid_decode");
    add_vec(0, 0, 4'h2, 1, 3'd3, 4'h2, 0, 0, 0, 8'd5, "mid_read");
    add_vec(0, 0, 4'h2, 1, 3'd4, 4'h2, 0, 0, 0, 8'd5, "mid_exec");
    add_vec(1, 1, 4'h2, 1, 3'd0, 4'h0, 0, 0, 0, 8'd0, "mid_exec_reset");
    add_vec(0, 0, 4'h2, 1, 3'd0, 4'h0, 0, 0, 0, 8'd0, "idle_no_run");

    foreach (vecs[i]) begin
      @(negedge clock);
      state_machine_reset = vecs[i].rst;
      run       = vecs[i].run;
      opcode    = vecs[i].opc;
      mem_ready = vecs[i].rdy;
      exp_q.push_back(vecs[i].exp);
      @(posedge clock);
      #1;
      got = '{st: state, os: opcode_store, fs: fetch_strobe, hl: halted,
              to: mem_timeout, cnt: instr_count};
      e = exp_q.pop_front();
      vec_cnt++;
      if (got !== e) begin
        miss_cnt++;
        $display("FAIL %s [%0d]: got st=%0d os=%h fs=%b hl=%b to=%b cnt=%0d, expected st=%0d os=%h fs=%b hl=%b to=%b cnt=%0d",
                 vecs[i].name, i, got.st, got.os, got.fs, got.hl, got.to, got.cnt,
                 e.st, e.os, e.fs, e.hl, e.to, e.cnt);
      end
    end

    // Narrow counter wraps; short timeout boundary on the second instance
    drive(1, 0, 4'h0, 0);
    chk("n_reset_state", 8'(state2), 8'd0);
    chk("n_reset_count", 8'(instr_count2), 8'd0);
    drive(0, 1, 4'h0, 1);
    chk("n_fetch", 8'(state2), 8'd1);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 4'h0, 1);
      chk("n_nop_decode", 8'(state2), 8'd2);
      drive(0, 1, 4'h0, 1);
      chk("n_nop_count", 8'(instr_count2), 8'((k + 1) % 4));
    end
    drive(0, 1, 4'h0, 0);
    chk("n_wait1", 8'(state2), 8'd1);
    drive(0, 1, 4'h0, 1);
    chk("n_ready_wins_state", 8'(state2), 8'd2);
    chk("n_ready_wins_to", 8'(mem_timeout2), 8'd0);
    drive(0, 1, 4'h0, 1);
    chk("n_count_after", 8'(instr_count2), 8'd2);
    drive(0, 1, 4'h0, 0);
    chk("n_wait_again", 8'(state2), 8'd1);
    drive(0, 1, 4'h0, 0);
    chk("n_timeout_state", 8'(state2), 8'd7);
    chk("n_timeout_flag", 8'(mem_timeout2), 8'd1);
    chk("n_timeout_halted", 8'(halted2), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
